// File: rtl/orion_soc_types.sv
// rtl/orion_soc_types.sv - shared register map, status bit positions and UART TX state encoding
package orion_soc_types;

  localparam int ADDRW = 32;
  localparam int DATAW = 32;
  localparam int MASKW = 4;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  typedef enum logic [1:0] {
    REG_TXDATA = OFF_TXDATA[3:2],
    REG_STATUS = OFF_STATUS[3:2],
    REG_DIV    = OFF_DIV[3:2],
    REG_RSVD   = OFF_RSVD[3:2]
  } reg_sel_e;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // A divider of zero would never end a bit; run it as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/orion_uart_tx_if.sv
// rtl/orion_uart_tx_if.sv - core data-port request/response bundle for the UART TX block
interface orion_uart_tx_if;
  import orion_soc_types::*;

  logic [ADDRW-1:0] addr_i;
  logic [DATAW-1:0] wdata_i;
  logic [MASKW-1:0] mask_i;
  logic             we_i;
  logic             valid_i;
  logic [DATAW-1:0] rdata_o;
  logic             resp_o;

  modport master (output addr_i, wdata_i, mask_i, we_i, valid_i,
                  input  rdata_o, resp_o);
  modport slave  (input  addr_i, wdata_i, mask_i, we_i, valid_i,
                  output rdata_o, resp_o);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; pushes while full and pops while empty are ignored
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DATAW-1:0] wdata,
  input  logic             pop,
  output logic [DATAW-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/orion_uart_tx.sv
// rtl/orion_uart_tx.sv - memory-mapped 8N1 UART transmitter with FIFO, divider and sticky overflow
module orion_uart_tx
  import orion_soc_types::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  orion_uart_tx_if.slave      bus,
  output logic                tx_o
);

  reg_sel_e         sel;
  logic             wr_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             ovf_set;
  logic             ovf_clr;
  logic             busy;
  logic [DATAW-1:0] status_word;
  logic [DATAW-1:0] read_mux;
  logic             unused_bus;

  logic             ovf_q;
  logic [15:0]      div_q;
  logic             resp_q;
  logic [DATAW-1:0] rdata_q;

  tx_state_e        state;
  logic [7:0]       shreg;
  logic [15:0]      div_lat;
  logic [15:0]      cyc_cnt;
  logic [2:0]       bit_cnt;
  logic             bit_end;

  assign unused_bus = ^{bus.addr_i[ADDRW-1:4], bus.addr_i[1:0],
                        bus.wdata_i[DATAW-1:16], bus.mask_i[MASKW-1:2]};

  assign sel       = reg_sel_e'(bus.addr_i[3:2]);
  assign wr_req    = bus.valid_i && bus.we_i;
  assign fifo_push = wr_req && (sel == REG_TXDATA) && bus.mask_i[0];
  assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;
  // A push against a full FIFO is lost even if the FSM pops in the same cycle.
  assign ovf_set   = fifo_push && fifo_full;
  assign ovf_clr   = wr_req && (sel == REG_STATUS) && bus.mask_i[0] && bus.wdata_i[3];
  assign busy      = (state != TX_IDLE) || !fifo_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATAW (8)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .wdata (bus.wdata_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word               = '0;
    status_word[STATUS_BUSY]  = busy;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_OVF]   = ovf_q;
  end

  always_comb begin
    read_mux = '0;
    case (sel)
      REG_STATUS: read_mux = status_word;
      REG_DIV:    read_mux = {{(DATAW-16){1'b0}}, div_q};
      default:    read_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= 16'(CLK_DIV);
    end else begin
      resp_q  <= bus.valid_i;
      rdata_q <= (bus.valid_i && !bus.we_i) ? read_mux : '0;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (wr_req && (sel == REG_DIV)) begin
        if (bus.mask_i[0]) div_q[7:0]  <= bus.wdata_i[7:0];
        if (bus.mask_i[1]) div_q[15:8] <= bus.wdata_i[15:8];
      end
    end
  end

  assign bus.resp_o  = resp_q;
  assign bus.rdata_o = rdata_q;

  assign bit_end = (cyc_cnt == div_lat - 16'd1);

  // tx_o is updated on the edge that enters each bit, so every bit lasts div_lat cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= TX_IDLE;
      tx_o    <= 1'b1;
      shreg   <= '0;
      div_lat <= 16'd1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            shreg   <= fifo_rdata;
            div_lat <= eff_div(div_q);
            cyc_cnt <= '0;
            bit_cnt <= '0;
            tx_o    <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            tx_o    <= shreg[0];
            state   <= TX_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_o  <= 1'b1;
              state <= TX_STOP;
            end else begin
              tx_o    <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= TX_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orion_uart_tx.sv
// tb/tb_orion_uart_tx.sv - directed bench with response scoreboard and serial frame checker
module tb_orion_uart_tx;

  localparam logic [31:0] A_TXDATA = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_DIV    = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } sb_t;

  logic clk;
  logic rst;
  logic tx;
  int   tests;
  int   fails;
  int   gap;
  logic exp_resp;
  sb_t  sb[$];

  orion_uart_tx_if bus();

  orion_uart_tx #(
    .CLK_DIV    (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .tx_o  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] m, input logic chk, input logic [31:0] exp);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wd;
    bus.mask_i  = m;
    sb.push_back('{chk: chk, data: exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
    bus_op(1'b1, addr, wd, m, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_op(1'b0, addr, 32'h0, 4'h0, 1'b1, exp);
  endtask

  task automatic bus_idle();
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.we_i    = 1'b0;
  endtask

  // Leaves the caller on the last stop-bit cycle; gap = idle cycles before the start bit.
  task automatic expect_frame(input logic [7:0] b, input int div, output int g);
    logic [9:0] bits;
    int n;
    bits = {1'b1, b, 1'b0};
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    g = n;
    tests++;
    assert (n < 400) else begin
      fails++;
      $error("FAIL frame_timeout: observed no start bit expected byte %h", b);
    end
    if (n < 400) begin
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < div; c++) begin
          if (!(i == 0 && c == 0)) @(negedge clk);
          check($sformatf("frame_%02h_bit%0d", b, i), {31'b0, tx}, {31'b0, bits[i]});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_resp = 1'b0;
    end else begin
      check("resp_timing", {31'b0, bus.resp_o}, {31'b0, exp_resp});
      if (bus.resp_o === 1'b1) begin
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL sb_empty: observed response expected none");
        end
        if (sb.size() > 0) begin
          sb_t e;
          e = sb.pop_front();
          if (e.chk) check("load_data", bus.rdata_o, e.data);
        end
      end else begin
        check("rdata_idle", bus.rdata_o, 32'h0);
      end
      exp_resp = bus.valid_i;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests       = 0;
    fails       = 0;
    exp_resp    = 1'b0;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.mask_i  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_resp", {31'b0, bus.resp_o}, 32'h0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    rst = 1'b0;
    rd(A_STATUS, 32'h4);
    rd(A_DIV, 32'd16);
    rd(A_TXDATA, 32'h0);
    rd(A_RSVD, 32'h0);
    bus_idle();

    // Single byte 0x55 at DIV=4, then idle
    wr(A_DIV, 32'd4, 4'hF);
    wr(A_TXDATA, 32'h55, 4'h1);
    bus_idle();
    expect_frame(8'h55, 4, gap);
    rd(A_STATUS, 32'h4);
    bus_idle();

    // Back-to-back mixed loads/stores, byte masks, reserved slot
    wr(A_DIV, 32'h0000_00AB, 4'h3);
    rd(A_DIV, 32'h0000_00AB);
    wr(A_DIV, 32'hFFFF_1200, 4'h2);
    rd(A_DIV, 32'h0000_12AB);
    wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    rd(A_RSVD, 32'h0);
    wr(A_TXDATA, 32'h77, 4'h2);
    rd(A_STATUS, 32'h4);
    rd(A_TXDATA, 32'h0);
    bus_idle();
    repeat (3) @(posedge clk);

    // Mid-frame DIV change applies at the next frame; DIV=0 runs 1-cycle bits
    wr(A_DIV, 32'd2, 4'hF);
    wr(A_TXDATA, 32'hA3, 4'h1);
    bus_idle();
    fork
      begin
        expect_frame(8'hA3, 2, gap);
        expect_frame(8'h3C, 6, gap);
        check("gap_div_change", gap, 32'd1);
      end
      begin
        repeat (5) @(posedge clk);
        wr(A_DIV, 32'd6, 4'hF);
        wr(A_TXDATA, 32'h3C, 4'h1);
        bus_idle();
      end
    join
    wr(A_DIV, 32'd0, 4'hF);
    rd(A_DIV, 32'd0);
    wr(A_TXDATA, 32'h81, 4'h1);
    bus_idle();
    expect_frame(8'h81, 1, gap);
    repeat (3) @(posedge clk);

    // Overflow: ninth push into a full FIFO is dropped, OVF sticky until cleared
    wr(A_DIV, 32'd20, 4'hF);
    wr(A_TXDATA, 32'hC7, 4'h1);
    bus_idle();
    fork
      begin
        expect_frame(8'hC7, 20, gap);
        for (int k = 0; k < 8; k++) begin
          expect_frame(8'h10 + 8'(k), 2, gap);
          check("gap_queued", gap, 32'd1);
        end
      end
      begin
        repeat (4) @(posedge clk);
        for (int k = 0; k < 9; k++) wr(A_TXDATA, 32'h10 + k, 4'h1);
        rd(A_STATUS, 32'hB);
        wr(A_STATUS, 32'h8, 4'h1);
        rd(A_STATUS, 32'h3);
        wr(A_DIV, 32'd2, 4'hF);
        bus_idle();
      end
    join
    rd(A_STATUS, 32'h4);
    bus_idle();
    repeat (3) @(posedge clk);

    // Reset mid-DATA with three bytes queued and a load in flight
    wr(A_DIV, 32'd4, 4'hF);
    for (int k = 0; k < 4; k++) wr(A_TXDATA, 32'h00, 4'h1);
    bus_idle();
    repeat (6) @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_tx_low", {31'b0, tx}, 32'h0);
    bus.valid_i = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = A_STATUS;
    sb.push_back('{chk: 1'b1, data: 32'h0});
    #2;
    rst = 1'b1;
    #1;
    bus.valid_i = 1'b0;
    check("mid_rst_tx", {31'b0, tx}, 32'h1);
    check("mid_rst_resp", {31'b0, bus.resp_o}, 32'h0);
    check("mid_rst_rdata", bus.rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    rd(A_STATUS, 32'h4);
    rd(A_DIV, 32'd16);
    bus_idle();
    repeat (4) @(posedge clk);
    check("final_tx_idle", {31'b0, tx}, 32'h1);
    check("sb_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
